// File: rtl/prim_clock_gate_ctrl_pkg.sv
// Shared types for prim_clock_gate_ctrl.
package prim_clock_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } gate_state_e;

  localparam int unsigned STATS_W = 32;

  // Bits needed to hold 0..n, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/prim_clock_gate_ctrl.sv
// Idle-detecting enable controller for a clock-gate cell.
// Optional gated-cycle statistics: PRIM_CLOCK_GATE_CTRL_STATS_EN.
module prim_clock_gate_ctrl
  import prim_clock_gate_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 gate_allow_i,
  input  logic                 busy_i,
  input  logic                 wake_i,
  output logic                 en_o,
  output logic                 gated_o,
  output logic                 wake_ready_o
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
  ,
  input  logic                 stats_clr_i,
  output logic [STATS_W-1:0]   gated_cycles_o
`endif
);

  localparam int unsigned IDLE_W = cnt_width(IDLE_CYCLES);
  localparam int unsigned WAKE_W = cnt_width(WAKE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST =
    WAKE_W'((WAKE_CYCLES == 0) ? 0 : (WAKE_CYCLES - 1));

  gate_state_e       state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic              idle;

  assign idle = gate_allow_i & ~busy_i & ~wake_i;

  // Counters default to zero so they clear on every state exit and on any
  // non-idle sample; only the staying-in-state branches advance them.
  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = '0;
    settle_cnt_d = '0;
    case (state_q)
      RUN: begin
        if (idle) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d = GATED;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
      end
      GATED: begin
        if (wake_i || !gate_allow_i) begin
          if (WAKE_CYCLES == 0) begin
            state_d = RUN;
          end else begin
            state_d = WAKE;
          end
        end
      end
      WAKE: begin
        if ((WAKE_CYCLES == 0) || (settle_cnt_q == WAKE_LAST)) begin
          state_d = RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + WAKE_W'(1);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      idle_cnt_q   <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign en_o         = (state_q != GATED);
  assign gated_o      = (state_q == GATED);
  assign wake_ready_o = (state_q == RUN);

`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
  logic [STATS_W-1:0] gated_cycles_q, gated_cycles_d;

  always_comb begin
    gated_cycles_d = gated_cycles_q;
    if (stats_clr_i) begin
      gated_cycles_d = '0;
    end else if ((state_q == GATED) && (gated_cycles_q != '1)) begin
      gated_cycles_d = gated_cycles_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gated_cycles_q <= '0;
    end else begin
      gated_cycles_q <= gated_cycles_d;
    end
  end

  assign gated_cycles_o = gated_cycles_q;
`endif

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
module tb_prim_clock_gate_ctrl;

  localparam logic [2:0] O_RUN = 3'b101;  // {en, gated, wake_ready}
  localparam logic [2:0] O_GAT = 3'b010;
  localparam logic [2:0] O_WAK = 3'b100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, allow_a, busy_a, wake_a, en_a, gated_a, rdy_a;
  logic rst_b_n, allow_b, busy_b, wake_b, en_b, gated_b, rdy_b;
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
  logic        clr_a, clr_b;
  logic [31:0] gc_a, gc_b;
`endif

  prim_clock_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_a_n),
    .gate_allow_i (allow_a),
    .busy_i       (busy_a),
    .wake_i       (wake_a),
    .en_o         (en_a),
    .gated_o      (gated_a),
    .wake_ready_o (rdy_a)
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    ,
    .stats_clr_i    (clr_a),
    .gated_cycles_o (gc_a)
`endif
  );

  prim_clock_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(0)) dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_b_n),
    .gate_allow_i (allow_b),
    .busy_i       (busy_b),
    .wake_i       (wake_b),
    .en_o         (en_b),
    .gated_o      (gated_b),
    .wake_ready_o (rdy_b)
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    ,
    .stats_clr_i    (clr_b),
    .gated_cycles_o (gc_b)
`endif
  );

  typedef struct {
    int unsigned cyc;
    int unsigned dut;
    logic [2:0]  o;
    logic        st_chk;
    logic [31:0] st;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [2:0]  mon_got;
  int unsigned cycle = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: outputs are valid every cycle; pop all expectations due now.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      mon_e   = sb.pop_front();
      mon_got = (mon_e.dut == 1) ? {en_b, gated_b, rdy_b} : {en_a, gated_a, rdy_a};
      n_tests = n_tests + 1;
      if (mon_e.cyc != cycle || mon_got !== mon_e.o) begin
        n_fail = n_fail + 1;
        $display("FAIL %s dut%0d cyc %0d: en/gated/rdy got %b expected %b (due cyc %0d)",
                 mon_e.nm, mon_e.dut, cycle, mon_got, mon_e.o, mon_e.cyc);
      end
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
      if (mon_e.st_chk) begin
        n_tests = n_tests + 1;
        if (gc_a !== mon_e.st) begin
          n_fail = n_fail + 1;
          $display("FAIL %s gated_cycles got %h expected %h", mon_e.nm, gc_a, mon_e.st);
        end
      end
`endif
    end
  end

  task automatic push(input int unsigned d, input logic [2:0] o, input logic sc,
                      input logic [31:0] sv, input string nm, input int unsigned at);
    exp_t e;
    e.cyc = at; e.dut = d; e.o = o; e.st_chk = sc; e.st = sv; e.nm = nm;
    sb.push_back(e);
  endtask

  // Apply one cycle of inputs to dut_a; expectation is the state after the edge.
  task automatic va(input logic al, input logic bz, input logic wk,
                    input logic [2:0] o, input string nm);
    allow_a = al; busy_a = bz; wake_a = wk;
    push(0, o, 1'b0, 32'd0, nm, cycle + 1);
    @(posedge clk); #1;
  endtask

  task automatic vb(input logic al, input logic bz, input logic wk,
                    input logic [2:0] o, input string nm);
    allow_b = al; busy_b = bz; wake_b = wk;
    push(1, o, 1'b0, 32'd0, nm, cycle + 1);
    @(posedge clk); #1;
  endtask

`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
  task automatic vs(input logic al, input logic bz, input logic wk, input logic cl,
                    input logic [2:0] o, input logic [31:0] sv, input string nm);
    allow_a = al; busy_a = bz; wake_a = wk; clr_a = cl;
    push(0, o, 1'b1, sv, nm, cycle + 1);
    @(posedge clk); #1;
    clr_a = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a_n = 1'b0; allow_a = 1'b1; busy_a = 1'b0; wake_a = 1'b0;
    rst_b_n = 1'b0; allow_b = 1'b0; busy_b = 1'b0; wake_b = 1'b0;
`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    clr_a = 1'b0; clr_b = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    push(0, O_RUN, 1'b0, 32'd0, "reset_a", cycle);
    push(1, O_RUN, 1'b0, 32'd0, "reset_b", cycle);
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Basic gating after four idle samples, wake through settle.
    va(1, 0, 0, O_RUN, "idle1");
    va(1, 0, 0, O_RUN, "idle2");
    va(1, 0, 0, O_RUN, "idle3");
    va(1, 0, 0, O_GAT, "gate_at_4");
    va(1, 1, 0, O_GAT, "busy_ignored_gated");
    va(1, 0, 1, O_WAK, "wake_en_rise");
    va(1, 0, 0, O_WAK, "wake_settle");
    va(1, 0, 0, O_RUN, "wake_ready");

    // Busy on idle cycle 3 restarts the count.
    va(1, 0, 0, O_RUN, "b_idle1");
    va(1, 0, 0, O_RUN, "b_idle2");
    va(1, 1, 0, O_RUN, "busy_clear");
    for (int i = 0; i < 3; i++) va(1, 0, 0, O_RUN, "post_busy_idle");
    va(1, 0, 0, O_GAT, "regate_after_busy");

    // Permission drop ungates.
    va(0, 0, 0, O_WAK, "allow_drop_wake");
    va(0, 0, 0, O_WAK, "allow_drop_settle");
    va(0, 0, 0, O_RUN, "allow_drop_run");

    // Events on the final idle cycle prevent gating.
    for (int i = 0; i < 3; i++) va(1, 0, 0, O_RUN, "pre_wake_idle");
    va(1, 0, 1, O_RUN, "wake_final_idle");
    for (int i = 0; i < 3; i++) va(1, 0, 0, O_RUN, "pre_allow_idle");
    va(0, 0, 0, O_RUN, "allow_drop_final");
    for (int i = 0; i < 3; i++) va(1, 0, 0, O_RUN, "pre_busy_idle");
    va(1, 1, 0, O_RUN, "busy_final");
    for (int i = 0; i < 100; i++) va(0, 0, 0, O_RUN, "allow0_hold");

    // WAKE is not interruptible and the idle count restarts from zero.
    for (int i = 0; i < 3; i++) va(1, 0, 0, O_RUN, "g2_idle");
    va(1, 0, 0, O_GAT, "gate2");
    va(1, 0, 1, O_WAK, "wake2");
    va(1, 0, 0, O_WAK, "wake_no_regate");
    va(1, 0, 0, O_RUN, "wake2_done");
    for (int i = 0; i < 3; i++) va(1, 0, 0, O_RUN, "count_from_zero");
    va(1, 1, 0, O_RUN, "busy_park");

`ifdef PRIM_CLOCK_GATE_CTRL_STATS_EN
    vs(1, 1, 0, 1, O_RUN, 32'd0, "st_clr");
    for (int i = 0; i < 3; i++) vs(1, 0, 0, 0, O_RUN, 32'd0, "st_idle");
    vs(1, 0, 0, 0, O_GAT, 32'd0, "st_gate");
    for (int i = 0; i < 10; i++) vs(1, 0, 0, 0, O_GAT, 32'(i + 1), "st_count");
    vs(1, 0, 0, 1, O_GAT, 32'd0, "st_clr_wins");
    vs(1, 0, 0, 0, O_GAT, 32'd1, "st_resume");
    vs(1, 0, 1, 0, O_WAK, 32'd2, "st_wake");
    vs(1, 0, 0, 0, O_WAK, 32'd2, "st_wake_settle");
    vs(1, 0, 0, 0, O_RUN, 32'd2, "st_run");
    for (int i = 0; i < 3; i++) vs(1, 0, 0, 0, O_RUN, 32'd2, "st_idle2");
    vs(1, 0, 0, 0, O_GAT, 32'd2, "st_gate2");
    force dut_a.gated_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut_a.gated_cycles_q;
    vs(1, 0, 0, 0, O_GAT, 32'hFFFF_FFFF, "st_sat_reach");
    vs(1, 0, 0, 0, O_GAT, 32'hFFFF_FFFF, "st_sat_hold");
    vs(1, 0, 1, 0, O_WAK, 32'hFFFF_FFFF, "st_sat_wake");
    vs(1, 0, 0, 0, O_WAK, 32'hFFFF_FFFF, "st_sat_settle");
    vs(1, 0, 0, 0, O_RUN, 32'hFFFF_FFFF, "st_sat_run");
`endif

    // Second instance: one idle cycle to gate, no settle time.
    vb(1, 0, 0, O_GAT, "b_gate1");
    vb(1, 0, 0, O_GAT, "b_hold");
    vb(1, 0, 1, O_RUN, "b_wake_direct");
    vb(1, 0, 0, O_GAT, "b_regate");
    @(negedge clk); #1;
    rst_b_n = 1'b0;
    #1;
    n_tests = n_tests + 1;
    if ({en_b, gated_b, rdy_b} !== O_RUN) begin
      n_fail = n_fail + 1;
      $display("FAIL b_async_reset: en/gated/rdy got %b expected %b",
               {en_b, gated_b, rdy_b}, O_RUN);
    end
    @(posedge clk); #1;
    rst_b_n = 1'b1;
    vb(1, 0, 0, O_GAT, "b_after_reset");
    vb(0, 0, 0, O_RUN, "b_allow_drop");

    repeat (3) @(posedge clk);
    n_tests = n_tests + 1;
    if (sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
